// File: rtl/reg_file_mp_if.sv
// Bus interface for reg_file_mp: clear request/status, two write ports and packed read ports.
interface reg_file_mp_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NUM_RD     = 2
);
  logic                           clr;
  logic                           busy;
  logic                           wena0;
  logic                           wena1;
  logic [ADDR_WIDTH-1:0]          waddr0;
  logic [ADDR_WIDTH-1:0]          waddr1;
  logic [DATA_WIDTH-1:0]          wdata0;
  logic [DATA_WIDTH-1:0]          wdata1;
  logic [NUM_RD*ADDR_WIDTH-1:0]   raddr;
  logic [NUM_RD*DATA_WIDTH-1:0]   rdata;

  modport master (
    output clr, wena0, wena1, waddr0, waddr1, wdata0, wdata1, raddr,
    input  busy, rdata
  );

  modport slave (
    input  clr, wena0, wena1, waddr0, waddr1, wdata0, wdata1, raddr,
    output busy, rdata
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file: combinational bypassed reads, two prioritised write ports, sequential clear engine.
// Optional: define REG_FILE_ZERO_REG_EN to hardwire entry 0 to zero.
module reg_file_mp #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NUM_RD     = 2
) (
  input logic          clk,
  input logic          rst,
  reg_file_mp_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;
  logic                  r_busy;
  logic                  w_clr_we;
  logic                  w_we0;
  logic                  w_we1;
  logic                  w_zero_blk0;
  logic                  w_zero_blk1;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] w_lane [NUM_RD];

`ifdef REG_FILE_ZERO_REG_EN
  assign w_zero_blk0 = (bus.waddr0 == '0);
  assign w_zero_blk1 = (bus.waddr1 == '0);
`else
  assign w_zero_blk0 = 1'b0;
  assign w_zero_blk1 = 1'b0;
`endif

  // State, clear counter and registered busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == ST_CLEAR);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr_we    = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr_we  = 1'b1;
        w_cnt_nxt = ADDR_WIDTH'(r_cnt + 1'b1);
        if (r_cnt == '1) w_state_nxt = ST_READY;
      end
      ST_READY: begin
        if (bus.clr) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  // A clear request on the same edge wins over writes
  assign w_we0 = (r_state == ST_READY) && !bus.clr && bus.wena0 && !w_zero_blk0;
  assign w_we1 = (r_state == ST_READY) && !bus.clr && bus.wena1 && !w_zero_blk1;

  // Storage; port 1 is written last so it wins on an address collision
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_clr_we) begin
        r_mem[r_cnt] <= '0;
      end else begin
        if (w_we0) r_mem[bus.waddr0] <= bus.wdata0;
        if (w_we1) r_mem[bus.waddr1] <= bus.wdata1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_ra;
    logic                  w_zero_hit;
    logic [DATA_WIDTH-1:0] w_rd;

    assign w_ra = bus.raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef REG_FILE_ZERO_REG_EN
    assign w_zero_hit = (w_ra == '0);
`else
    assign w_zero_hit = 1'b0;
`endif

    // Bypass precedence: port 1, then port 0, then stored entry
    always_comb begin
      w_rd = '0;
      if (r_state == ST_READY && !w_zero_hit) begin
        if (bus.wena1 && bus.waddr1 == w_ra)      w_rd = bus.wdata1;
        else if (bus.wena0 && bus.waddr0 == w_ra) w_rd = bus.wdata0;
        else                                      w_rd = r_mem[w_ra];
      end
    end

    assign w_lane[k] = w_rd;
  end

  always_comb begin
    bus.rdata = '0;
    for (int k = 0; k < NUM_RD; k++) bus.rdata[k*DATA_WIDTH +: DATA_WIDTH] = w_lane[k];
  end

  assign bus.busy = r_busy;
endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus random traffic against a behavioural model.
module tb_reg_file_mp;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned NR    = 2;
  localparam int unsigned DEPTH = 2 ** AW;
`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  reg_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) bus ();

  reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: contents plus number of clear cycles still owed
  logic [DW-1:0] model_mem [DEPTH];
  int            clear_left;

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (clear_left > 0)        return '0;
    if (ZERO_EN && a == 0)     return '0;
    if (bus.wena1 && bus.waddr1 == a) return bus.wdata1;
    if (bus.wena0 && bus.waddr0 == a) return bus.wdata0;
    return model_mem[a];
  endfunction

  task automatic model_edge();
    if (rst) begin
      clear_left = DEPTH;
    end else if (clear_left > 0) begin
      model_mem[DEPTH - clear_left] = '0;
      clear_left--;
    end else if (bus.clr) begin
      clear_left = DEPTH;
    end else begin
      if (bus.wena0 && !(ZERO_EN && bus.waddr0 == 0)) model_mem[bus.waddr0] = bus.wdata0;
      if (bus.wena1 && !(ZERO_EN && bus.waddr1 == 0)) model_mem[bus.waddr1] = bus.wdata1;
    end
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("busy", DW'(bus.busy), DW'(clear_left > 0));
    for (int k = 0; k < NR; k++)
      check($sformatf("rdata%0d[a=%0d]", k, bus.raddr[k*AW +: AW]),
            bus.rdata[k*DW +: DW], model_read(bus.raddr[k*AW +: AW]));
  endtask

  // Check outputs mid-cycle, advance one edge, update the model from the sampled inputs
  task automatic cyc();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic c,
                       input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    rst        = r;
    bus.clr    = c;
    bus.wena0  = we0; bus.waddr0 = a0; bus.wdata0 = d0;
    bus.wena1  = we1; bus.waddr1 = a1; bus.wdata1 = d1;
    bus.raddr  = {ra1, ra0};
  endtask

  task automatic idle_read(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, ra0, ra1);
  endtask

  task automatic rand_traffic(input int n, input int clr_odds, input int rst_odds);
    for (int i = 0; i < n; i++) begin
      drive(rst_odds > 0 && $urandom_range(rst_odds - 1) == 0,
            clr_odds > 0 && $urandom_range(clr_odds - 1) == 0,
            1'($urandom), AW'($urandom), $urandom,
            1'($urandom), AW'($urandom), $urandom,
            AW'($urandom), AW'($urandom));
      cyc();
    end
  endtask

  initial begin
    clear_left = 0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 'x;
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc();                         // second reset cycle

    // Reset then clear, with ignored write attempts during busy
    rand_traffic(DEPTH, 0, 0);
    idle_read(4'd0, 4'd1);
    check("busy_low_after_clear", DW'(bus.busy), DW'(0));
    for (int a = 0; a < DEPTH; a += 2) begin
      idle_read(AW'(a), AW'(a + 1));
      #1;
      check("cleared0", bus.rdata[0 +: DW], '0);
      check("cleared1", bus.rdata[DW +: DW], '0);
      cyc();
    end

    // Write then read on both lanes
    drive(1'b0, 1'b0, 1'b1, 4'd5, 32'hDEADBEEF, 1'b0, '0, '0, 4'd1, 4'd2);
    cyc();
    idle_read(4'd5, 4'd5);
    #1;
    check("r5_lane0", bus.rdata[0 +: DW], 32'hDEADBEEF);
    check("r5_lane1", bus.rdata[DW +: DW], 32'hDEADBEEF);
    cyc();

    // Bypass and priority
    drive(1'b0, 1'b0, 1'b1, 4'd3, 32'h11, 1'b1, 4'd3, 32'h22, 4'd3, 4'd5);
    #1;
    check("bypass_r3", bus.rdata[0 +: DW], 32'h22);
    cyc();
    idle_read(4'd3, 4'd3);
    #1;
    check("r3_held", bus.rdata[DW +: DW], 32'h22);
    cyc();

    // Clear while writing r7
    drive(1'b0, 1'b0, 1'b1, 4'd7, 32'h1234, 1'b0, '0, '0, 4'd7, 4'd0);
    cyc();
    drive(1'b0, 1'b1, 1'b1, 4'd7, 32'h55, 1'b0, '0, '0, 4'd7, 4'd3);
    cyc();
    rand_traffic(DEPTH, 0, 0);
    idle_read(4'd7, 4'd3);
    #1;
    check("r7_cleared", bus.rdata[0 +: DW], '0);
    check("busy_done_a", DW'(bus.busy), DW'(0));
    cyc();

    // Reset at clear cycle 9
    drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
    cyc();
    rand_traffic(8, 0, 0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
    cyc();
    for (int i = 0; i < DEPTH; i++) begin
      idle_read(AW'(i), 4'd9);
      #1;
      check("busy_after_midreset", DW'(bus.busy), DW'(1));
      cyc();
    end
    idle_read(4'd0, 4'd9);
    check("busy_low_midreset", DW'(bus.busy), DW'(0));

    // Zero register
    drive(1'b0, 1'b0, 1'b1, 4'd0, 32'hFFFF, 1'b0, '0, '0, 4'd0, 4'd1);
    #1;
    check("r0_write_cycle", bus.rdata[0 +: DW], ZERO_EN ? 32'h0 : 32'hFFFF);
    cyc();
    idle_read(4'd0, 4'd0);
    #1;
    check("r0_after", bus.rdata[0 +: DW], ZERO_EN ? 32'h0 : 32'hFFFF);
    cyc();
    drive(1'b0, 1'b0, 1'b1, 4'd0, 32'hABCD, 1'b1, 4'd0, 32'h1357, 4'd0, 4'd0);
    cyc();

    // Random traffic with occasional clear and reset
    rand_traffic(400, 40, 150);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
